// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: drain FSM encoding and default depth.
package uart_pkg;

    localparam int unsigned UART_TXQ_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } drain_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer/UART-side signal bundle for uart_tx_queue.
// master = surrounding logic (producer plus UART busy), slave = the queue.
interface uart_tx_queue_if;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] uart_din;
    logic       uart_start;
    logic       uart_busy;

    modport master (
        output wr_en, wr_data, clr_ovf, uart_busy,
        input  full, empty, overflow, uart_din, uart_start
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, uart_busy,
        output full, empty, overflow, uart_din, uart_start
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Byte storage for the transmit queue: synchronous write, asynchronous head read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = UART_TXQ_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter through a four-state drain FSM.
// Optional macro UART_TXQ_LEVEL_EN adds the level (entry count) output.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_TXQ_DEPTH
) (
    input  logic clk,
    input  logic rst,
    uart_tx_queue_if.slave bus
`ifdef UART_TXQ_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    drain_state_e state_q, state_d;
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         ovf_q, ovf_d;
    logic [7:0]   din_q, din_d;
    logic [7:0]   head;
    logic         full, empty, push, pop, load, start;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus.wr_en && !full;

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty && !bus.uart_busy) state_d = LOAD;
            LOAD:    state_d = WAIT_HI;
            WAIT_HI: if (bus.uart_busy) state_d = WAIT_LO;
            WAIT_LO: if (!bus.uart_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The head byte is latched on the edge entering LOAD and popped on the edge leaving it.
    always_comb begin
        load  = (state_q == IDLE) && (state_d == LOAD);
        pop   = (state_q == LOAD);
        start = (state_q == LOAD);
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        din_d    = load ? head : din_q;
        ovf_d    = ovf_q;
        if (bus.wr_en && full) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // uart_busy is an input only, so a transfer already in the UART runs on through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            din_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            din_q    <= din_d;
        end
    end

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.overflow   = ovf_q;
    assign bus.uart_din   = din_q;
    assign bus.uart_start = start;

`ifdef UART_TXQ_LEVEL_EN
    assign level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: byte-queue reference model plus a UART busy model.
module tb_uart_tx_queue;

    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_queue_if bus ();
`ifdef UART_TXQ_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    uart_tx_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus)
`ifdef UART_TXQ_LEVEL_EN
        ,
        .level (level)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] ref_q [$];
    logic       ref_ovf = 1'b0;
    logic [7:0] cap_q [$];
    logic [7:0] in_q  [$];
    int         n_starts = 0;

    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    int   dly  = 0;
    int   hold = 0;
    logic prev_empty = 1'b1;

    assign bus.uart_busy = model_busy | force_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // UART transmitter: busy rises 2 cycles after a start and stays high 10 cycles.
    always @(negedge clk) begin
        if (bus.uart_start === 1'b1) begin
            chk("start_while_busy", 32'(model_busy | force_busy | (dly != 0)), 32'd0);
            chk("start_after_empty", 32'(prev_empty), 32'd0);
            cap_q.push_back(bus.uart_din);
            n_starts++;
            dly = 2;
        end else if (dly != 0) begin
            dly--;
            if (dly == 0) begin
                model_busy = 1'b1;
                hold = 10;
            end
        end else if (hold != 0) begin
            hold--;
            if (hold == 0) model_busy = 1'b0;
        end
        prev_empty = bus.empty;
    end

    // One clock: predict the edge from current inputs, then check flags at the next negedge.
    task automatic step();
        bit         push_ok, ovf_hit, popped;
        logic [7:0] exp_b;
        push_ok = (bus.wr_en === 1'b1) && (ref_q.size() < DEPTH);
        ovf_hit = (bus.wr_en === 1'b1) && (ref_q.size() == DEPTH);
        popped  = (bus.uart_start === 1'b1);
        if (rst) begin
            ref_q.delete();
            ref_ovf = 1'b0;
        end else begin
            if (popped) begin
                chk("pop_nonempty", 32'(ref_q.size() != 0), 32'd1);
                if (ref_q.size() != 0) begin
                    exp_b = ref_q.pop_front();
                    chk("uart_din", 32'(bus.uart_din), 32'(exp_b));
                end
            end
            if (push_ok) ref_q.push_back(bus.wr_data);
            if (ovf_hit) ref_ovf = 1'b1;
            else if (bus.clr_ovf) ref_ovf = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("empty", 32'(bus.empty), 32'(ref_q.size() == 0));
        chk("full", 32'(bus.full), 32'(ref_q.size() == DEPTH));
        chk("overflow", 32'(bus.overflow), 32'(ref_ovf));
`ifdef UART_TXQ_LEVEL_EN
        chk("level", 32'(level), 32'(ref_q.size()));
        chk("level_max", 32'(level <= DEPTH), 32'd1);
`endif
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (bus.uart_start !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("start_seen", 32'(bus.uart_start), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((ref_q.size() != 0 || model_busy || dly != 0 || hold != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", 32'(n < budget), 32'd1);
        repeat (3) step();
    endtask

    initial begin
        int t0, s0, c0, n;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_ovf = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_start", 32'(bus.uart_start), 32'd0);
        chk("rst_din", 32'(bus.uart_din), 32'd0);

        // single byte: latency and pulse width
        t0 = cyc;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h55;
        step();
        bus.wr_en = 1'b0;
        chk("start_not_early", 32'(bus.uart_start), 32'd0);
        wait_start(20);
        chk("start_latency", 32'(cyc - t0), 32'd2);
        chk("start_din", 32'(bus.uart_din), 32'h55);
        step();
        chk("empty_after_load", 32'(bus.empty), 32'd1);
        chk("start_one_cycle", 32'(bus.uart_start), 32'd0);
        chk("din_holds", 32'(bus.uart_din), 32'h55);
        drain(200);

        // fill to full while UART is busy, overflow and clear priority
        force_busy = 1'b1;
        s0 = n_starts;
        for (int i = 1; i <= 8; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            step();
        end
        chk("full_after_8", 32'(bus.full), 32'd1);
        chk("ovf_before_9", 32'(bus.overflow), 32'd0);
        bus.wr_data = 8'hFF;
        step();
        chk("ovf_after_9", 32'(bus.overflow), 32'd1);
        bus.wr_data = 8'hEE;
        bus.clr_ovf = 1'b1;
        step();
        chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
        bus.wr_en = 1'b0;
        step();
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        bus.clr_ovf = 1'b0;
        chk("no_start_while_forced", 32'(n_starts - s0), 32'd0);
        force_busy = 1'b0;
        c0 = cap_q.size();
        drain(400);
        chk("starts_8", 32'(n_starts - s0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("order_1_8", 32'(cap_q[c0 + i]), 32'(i + 1));
        end

        // reset while the FSM waits for busy to fall
        s0 = n_starts;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'hC0 + i);
            step();
        end
        bus.wr_en = 1'b0;
        n = 0;
        while (!model_busy && n < 50) begin
            step();
            n++;
        end
        chk("busy_seen", 32'(model_busy), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_empty", 32'(bus.empty), 32'd1);
        chk("rst2_start", 32'(bus.uart_start), 32'd0);
        chk("rst2_din", 32'(bus.uart_din), 32'd0);
        drain(100);
        repeat (10) step();
        chk("no_start_after_rst", 32'(n_starts - s0), 32'd1);
        t0 = cyc;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hA5;
        step();
        bus.wr_en = 1'b0;
        wait_start(20);
        chk("idle_after_rst_latency", 32'(cyc - t0), 32'd2);
        chk("idle_after_rst_din", 32'(bus.uart_din), 32'hA5);
        drain(200);

        // sustained random traffic, 40 accepted bytes (5 pointer wraps)
        c0 = cap_q.size();
        n  = 0;
        while (in_q.size() < 40 && n < 3000) begin
            bus.wr_en   = ($urandom_range(0, 3) != 0);
            bus.wr_data = 8'($urandom);
            if (bus.wr_en && ref_q.size() < DEPTH) in_q.push_back(bus.wr_data);
            step();
            n++;
        end
        bus.wr_en = 1'b0;
        chk("accepted_40", 32'(in_q.size()), 32'd40);
        drain(1000);
        chk("out_count", 32'(cap_q.size() - c0), 32'd40);
        for (int i = 0; i < in_q.size(); i++) begin
            chk("seq", 32'(cap_q[c0 + i]), 32'(in_q[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
